// File: rtl/zacore_pkg.sv
// rtl/zacore_pkg.sv - shared types for the zacore memory arbiter
package zacore_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} mem_arb_state_e;
  typedef enum logic {GRANT_DATA, GRANT_FETCH} mem_grant_e;

endpackage

// File: rtl/zacore_arb_prio.sv
// rtl/zacore_arb_prio.sv - fetch/data grant decision with data-streak starvation guard
module zacore_arb_prio
  import zacore_pkg::*;
#(
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic fetch_pend,
  input  logic data_pend,
  input  logic grant_en,
  output logic grant_fetch
);

  // A zero limit still needs one counter bit; it simply never leaves 0.
  localparam int SW = (DATA_STREAK_MAX > 0) ? $clog2(DATA_STREAK_MAX + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);

  logic [SW-1:0] streak_q;

  assign grant_fetch = fetch_pend && (!data_pend || (streak_q == STREAK_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else if (grant_en) begin
      if (!grant_fetch && fetch_pend) begin
        if (streak_q != STREAK_MAX) streak_q <= streak_q + 1'b1;
      end else begin
        streak_q <= '0;
      end
    end
  end

endmodule

// File: rtl/zacore_mem_arbiter.sv
// rtl/zacore_mem_arbiter.sv - single-outstanding arbiter sharing one memory port
// between instruction fetch and data load/store.
module zacore_mem_arbiter
  import zacore_pkg::*;
#(
  parameter int DATA_STREAK_MAX = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_fetch_req,
  input  logic [XLEN-1:0] i_fetch_addr,
  output logic            o_fetch_valid,
  output logic [XLEN-1:0] o_inst_read,
  input  logic            i_read_req,
  input  logic            i_write_req,
  input  logic [XLEN-1:0] i_data_addr,
  input  logic [XLEN-1:0] i_data_write,
  input  logic [3:0]      i_data_write_mask,
  output logic            o_data_valid,
  output logic [XLEN-1:0] o_data_read,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_wmask,
  input  logic            i_mem_ready,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_grant_fetch
);

  mem_arb_state_e state_q, state_d;
  mem_grant_e     grant_q, grant_d;

  logic            data_pend, grant_en, grant_fetch;
  logic            req_d, we_d, fv_d, dv_d;
  logic [XLEN-1:0] addr_d, wdata_d, inst_d, dread_d;
  logic [3:0]      wmask_d;

  assign data_pend     = i_read_req | i_write_req;
  assign grant_en      = (state_q == IDLE) && (i_fetch_req || data_pend);
  assign o_grant_fetch = (grant_q == GRANT_FETCH);

  zacore_arb_prio #(
    .DATA_STREAK_MAX(DATA_STREAK_MAX)
  ) u_prio (
    .clk        (i_clk),
    .rst        (i_rst),
    .fetch_pend (i_fetch_req),
    .data_pend  (data_pend),
    .grant_en   (grant_en),
    .grant_fetch(grant_fetch)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    req_d   = o_mem_req;
    we_d    = o_mem_we;
    addr_d  = o_mem_addr;
    wdata_d = o_mem_wdata;
    wmask_d = o_mem_wmask;
    fv_d    = 1'b0;
    dv_d    = 1'b0;
    inst_d  = o_inst_read;
    dread_d = o_data_read;
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          state_d = ISSUE;
          req_d   = 1'b1;
          if (grant_fetch) begin
            grant_d = GRANT_FETCH;
            we_d    = 1'b0;
            addr_d  = i_fetch_addr;
            wdata_d = '0;
            wmask_d = '0;
          end else begin
            // A simultaneous read and write is served as the write alone.
            grant_d = GRANT_DATA;
            we_d    = i_write_req;
            addr_d  = i_data_addr;
            wdata_d = i_data_write;
            wmask_d = i_write_req ? i_data_write_mask : 4'b0000;
          end
        end
      end
      ISSUE: begin
        if (i_mem_ready) begin
          req_d   = 1'b0;
          state_d = o_mem_we ? RESP : WAIT_RD;
          dv_d    = o_mem_we;
        end
      end
      WAIT_RD: begin
        if (i_mem_rvalid) begin
          state_d = RESP;
          if (grant_q == GRANT_FETCH) begin
            inst_d = i_mem_rdata;
            fv_d   = 1'b1;
          end else begin
            dread_d = i_mem_rdata;
            dv_d    = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      grant_q       <= GRANT_DATA;
      o_mem_req     <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= '0;
      o_mem_wmask   <= '0;
      o_fetch_valid <= 1'b0;
      o_data_valid  <= 1'b0;
      o_inst_read   <= '0;
      o_data_read   <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      o_mem_req     <= req_d;
      o_mem_we      <= we_d;
      o_mem_addr    <= addr_d;
      o_mem_wdata   <= wdata_d;
      o_mem_wmask   <= wmask_d;
      o_fetch_valid <= fv_d;
      o_data_valid  <= dv_d;
      o_inst_read   <= inst_d;
      o_data_read   <= dread_d;
    end
  end

endmodule

// File: tb/tb_zacore_mem_arbiter.sv
// tb/tb_zacore_mem_arbiter.sv - self-checking bench for zacore_mem_arbiter
module tb_zacore_mem_arbiter;

  localparam int DSM = 4;
  localparam logic [31:0] DB = 32'hDEADBEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, freq, rreq, wreq, rdy, rv;
  logic [31:0] faddr, daddr, wdata, rdata;
  logic [3:0]  wmask;
  logic        fv, dv, mreq, mwe, gf;
  logic [31:0] inst, dread, maddr, mwdata;
  logic [3:0]  mwmask;

  logic        z_rst, z_freq, z_rreq, z_wreq, z_rdy, z_rv;
  logic [31:0] z_faddr, z_daddr, z_wdata, z_rdata;
  logic [3:0]  z_wmask;
  logic        z_fv, z_dv, z_mreq, z_mwe, z_gf;
  logic [31:0] z_inst, z_dread, z_maddr, z_mwdata;
  logic [3:0]  z_mwmask;

  zacore_mem_arbiter #(.DATA_STREAK_MAX(DSM)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_fetch_req(freq), .i_fetch_addr(faddr), .o_fetch_valid(fv), .o_inst_read(inst),
    .i_read_req(rreq), .i_write_req(wreq), .i_data_addr(daddr), .i_data_write(wdata),
    .i_data_write_mask(wmask), .o_data_valid(dv), .o_data_read(dread),
    .o_mem_req(mreq), .o_mem_we(mwe), .o_mem_addr(maddr), .o_mem_wdata(mwdata),
    .o_mem_wmask(mwmask), .i_mem_ready(rdy), .i_mem_rvalid(rv), .i_mem_rdata(rdata),
    .o_grant_fetch(gf)
  );

  zacore_mem_arbiter #(.DATA_STREAK_MAX(0)) dut0 (
    .i_clk(clk), .i_rst(z_rst),
    .i_fetch_req(z_freq), .i_fetch_addr(z_faddr), .o_fetch_valid(z_fv), .o_inst_read(z_inst),
    .i_read_req(z_rreq), .i_write_req(z_wreq), .i_data_addr(z_daddr), .i_data_write(z_wdata),
    .i_data_write_mask(z_wmask), .o_data_valid(z_dv), .o_data_read(z_dread),
    .o_mem_req(z_mreq), .o_mem_we(z_mwe), .o_mem_addr(z_maddr), .o_mem_wdata(z_mwdata),
    .o_mem_wmask(z_mwmask), .i_mem_ready(z_rdy), .i_mem_rvalid(z_rv), .i_mem_rdata(z_rdata),
    .o_grant_fetch(z_gf)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic r, fq, rq, wq, rd, rvi;
    logic [31:0] fa, da, wd, rdt;
    logic [3:0] wm;
    logic efv, edv, emq, emw, egf;
    logic [31:0] ema, emd, ein, edr;
    logic [3:0] emm;
  } vec_t;

  function automatic vec_t mk(input logic r, fq, input logic [31:0] fa, input logic rq, wq,
                              input logic [31:0] da, wd, input logic [3:0] wm, input logic rd, rvi,
                              input logic [31:0] rdt, input logic efv, edv, emq, emw,
                              input logic [31:0] ema, emd, input logic [3:0] emm,
                              input logic [31:0] ein, edr, input logic egf);
    vec_t v;
    v.r = r; v.fq = fq; v.fa = fa; v.rq = rq; v.wq = wq; v.da = da; v.wd = wd; v.wm = wm;
    v.rd = rd; v.rvi = rvi; v.rdt = rdt; v.efv = efv; v.edv = edv; v.emq = emq; v.emw = emw;
    v.ema = ema; v.emd = emd; v.emm = emm; v.ein = ein; v.edr = edr; v.egf = egf;
    return v;
  endfunction

  logic [31:0] dev_mem [8];
  logic [31:0] ref_mem [8];

  task automatic do_reset();
    rst = 1'b1; freq = 1'b0; rreq = 1'b0; wreq = 1'b0; rdy = 1'b0; rv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic new_data(input bit sat);
    rreq = 1'b0; wreq = 1'b0;
    if (sat) rreq = 1'b1;
    else begin
      case ($urandom_range(4))
        0, 1:    rreq = 1'b1;
        2, 3:    wreq = 1'b1;
        default: begin rreq = 1'b1; wreq = 1'b1; end
      endcase
    end
    daddr = 32'($urandom_range(7)) << 2;
    wdata = $urandom;
    wmask = 4'($urandom);
  endtask

  // Transaction-level scoreboard: arbitration rule, request capture and response data.
  task automatic run_traffic(input int cycles, input bit sat, output string order);
    bit out_tx = 0, acc = 0, t_fetch = 0, t_write = 0, last_valid = 0;
    bit dev_wait = 0;
    int dev_dly = 0, streak = 0;
    logic [31:0] t_addr = 0, t_wdata = 0, dev_addr = 0, e_data = 0;
    logic [3:0]  t_mask = 0;
    bit s_fp, s_dp, s_w, s_rdy, s_rv, s_mreq, s_mwe, e_fv, e_dv, e_mreq;
    logic [31:0] s_faddr, s_daddr, s_wdata, s_maddr, s_mwdata;
    logic [3:0]  s_wmask, s_mwmask;
    order = "";
    for (int c = 0; c < cycles; c++) begin
      if (!freq && (sat || $urandom_range(2) == 0)) begin
        freq = 1'b1;
        faddr = 32'($urandom_range(7)) << 2;
      end
      if (!rreq && !wreq && (sat || $urandom_range(2) == 0)) new_data(sat);
      rdy = sat ? 1'b1 : ($urandom_range(2) != 0);
      rv = 1'b0;
      rdata = $urandom;
      if (dev_wait) begin
        if (dev_dly == 0) begin
          rv = 1'b1;
          rdata = dev_mem[dev_addr[4:2]];
          dev_wait = 0;
        end else dev_dly--;
      end else if (mreq && !rdy && $urandom_range(3) == 0) rv = 1'b1;
      s_fp = freq; s_dp = rreq | wreq; s_w = wreq; s_faddr = faddr; s_daddr = daddr;
      s_wdata = wdata; s_wmask = wmask; s_rdy = rdy; s_rv = rv; s_mreq = mreq; s_mwe = mwe;
      s_maddr = maddr; s_mwdata = mwdata; s_mwmask = mwmask;
      @(posedge clk); #1;
      if (s_mreq && s_rdy) begin
        if (s_mwe) begin
          for (int b = 0; b < 4; b++)
            if (s_mwmask[b]) dev_mem[s_maddr[4:2]][8*b +: 8] = s_mwdata[8*b +: 8];
        end else begin
          dev_wait = 1;
          dev_addr = s_maddr;
          dev_dly = sat ? 0 : int'($urandom_range(3));
        end
      end
      e_fv = 0; e_dv = 0; e_mreq = 0;
      if (out_tx && !acc) begin
        if (s_rdy) begin
          acc = 1;
          if (t_write) begin
            e_dv = 1;
            out_tx = 0;
            for (int b = 0; b < 4; b++)
              if (t_mask[b]) ref_mem[t_addr[4:2]][8*b +: 8] = t_wdata[8*b +: 8];
          end
        end else e_mreq = 1;
      end else if (out_tx) begin
        if (s_rv) begin
          out_tx = 0;
          e_data = ref_mem[t_addr[4:2]];
          if (t_fetch) e_fv = 1; else e_dv = 1;
        end
      end else if (!last_valid && (s_fp || s_dp)) begin
        t_fetch = s_fp && (!s_dp || streak == DSM);
        if (t_fetch || !s_fp) streak = 0;
        else if (streak < DSM) streak++;
        t_write = !t_fetch && s_w;
        t_addr  = t_fetch ? s_faddr : s_daddr;
        t_wdata = s_wdata;
        t_mask  = t_write ? s_wmask : 4'b0000;
        out_tx = 1; acc = 0; e_mreq = 1;
        order = {order, t_fetch ? "F" : "D"};
      end
      last_valid = e_fv || e_dv;
      chk("rnd fetch_valid", fv, e_fv);
      chk("rnd data_valid", dv, e_dv);
      chk("rnd mem_req", mreq, e_mreq);
      if (e_mreq) begin
        chk("rnd mem_addr", maddr, t_addr);
        chk("rnd mem_we", mwe, t_write);
        chk("rnd mem_wmask", mwmask, t_mask);
        chk("rnd grant_fetch", gf, t_fetch);
        if (t_write) chk("rnd mem_wdata", mwdata, t_wdata);
      end
      if (e_fv) chk("rnd inst_read", inst, e_data);
      if (e_dv && !t_write) chk("rnd data_read", dread, e_data);
      if (fv) begin
        if (sat || $urandom_range(1) == 0) faddr = 32'($urandom_range(7)) << 2;
        else freq = 1'b0;
      end
      if (dv) begin
        if (sat || $urandom_range(1) == 0) new_data(sat);
        else begin rreq = 1'b0; wreq = 1'b0; end
      end
    end
  endtask

  initial begin
    vec_t tbl[$];
    string order;
    rst = 1'b1; freq = 0; rreq = 0; wreq = 0; rdy = 0; rv = 0;
    faddr = 0; daddr = 0; wdata = 0; wmask = 0; rdata = 0;
    z_rst = 1'b1; z_freq = 0; z_rreq = 0; z_wreq = 0; z_rdy = 0; z_rv = 0;
    z_faddr = 0; z_daddr = 0; z_wdata = 0; z_wmask = 0; z_rdata = 0;

    // reset
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0));
    // fetch 0x100, ready at once, rdata one cycle after accept
    tbl.push_back(mk(0,1,'h100,0,0,0,0,0,1,0,0, 0,0,1,0,'h100,0,0,0,0,1));
    tbl.push_back(mk(0,1,'h100,0,0,0,0,0,1,0,0, 0,0,0,0,'h100,0,0,0,0,1));
    tbl.push_back(mk(0,1,'h100,0,0,0,0,0,1,1,DB, 1,0,0,0,'h100,0,0,DB,0,1));
    tbl.push_back(mk(0,1,'h100,0,0,0,0,0,1,0,0, 0,0,0,0,'h100,0,0,DB,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,0, 0,0,0,0,'h100,0,0,DB,0,1));
    // write 0x200 with ready held off three cycles
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,0,1,'h200,'h11223344,4'b0101,0,0,0, 0,0,1,1,'h200,'h11223344,4'b0101,DB,0,0));
    tbl.push_back(mk(0,0,0,0,1,'h200,'h11223344,4'b0101,1,0,0, 0,1,0,1,'h200,'h11223344,4'b0101,DB,0,0));
    tbl.push_back(mk(0,0,0,0,1,'h200,'h11223344,4'b0101,1,0,0, 0,0,0,1,'h200,'h11223344,4'b0101,DB,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,0, 0,0,0,1,'h200,'h11223344,4'b0101,DB,0,0));
    // read and write together: one write only
    tbl.push_back(mk(0,0,0,1,1,'h300,'hAABBCCDD,4'hF,1,0,0, 0,0,1,1,'h300,'hAABBCCDD,4'hF,DB,0,0));
    tbl.push_back(mk(0,0,0,1,1,'h300,'hAABBCCDD,4'hF,1,0,0, 0,1,0,1,'h300,'hAABBCCDD,4'hF,DB,0,0));
    tbl.push_back(mk(0,0,0,1,1,'h300,'hAABBCCDD,4'hF,1,0,0, 0,0,0,1,'h300,'hAABBCCDD,4'hF,DB,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,0, 0,0,0,1,'h300,'hAABBCCDD,4'hF,DB,0,0));
    // read, reset while waiting for data, late rvalid ignored
    tbl.push_back(mk(0,0,0,1,0,'h400,0,4'hF,1,0,0, 0,0,1,0,'h400,0,0,DB,0,0));
    tbl.push_back(mk(0,0,0,1,0,'h400,0,4'hF,1,0,0, 0,0,0,0,'h400,0,0,DB,0,0));
    tbl.push_back(mk(1,0,0,1,0,'h400,0,4'hF,1,0,0, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,1,'h55, 0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0,0, 0,0,0,0,0,0,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r; freq = tbl[i].fq; faddr = tbl[i].fa; rreq = tbl[i].rq; wreq = tbl[i].wq;
      daddr = tbl[i].da; wdata = tbl[i].wd; wmask = tbl[i].wm; rdy = tbl[i].rd;
      rv = tbl[i].rvi; rdata = tbl[i].rdt;
      @(posedge clk); #1;
      chk($sformatf("v%0d fetch_valid", i), fv, tbl[i].efv);
      chk($sformatf("v%0d data_valid", i), dv, tbl[i].edv);
      chk($sformatf("v%0d mem_req", i), mreq, tbl[i].emq);
      chk($sformatf("v%0d mem_we", i), mwe, tbl[i].emw);
      chk($sformatf("v%0d mem_addr", i), maddr, tbl[i].ema);
      chk($sformatf("v%0d mem_wdata", i), mwdata, tbl[i].emd);
      chk($sformatf("v%0d mem_wmask", i), mwmask, tbl[i].emm);
      chk($sformatf("v%0d inst_read", i), inst, tbl[i].ein);
      chk($sformatf("v%0d data_read", i), dread, tbl[i].edr);
      chk($sformatf("v%0d grant_fetch", i), gf, tbl[i].egf);
    end

    for (int i = 0; i < 8; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end
    do_reset();
    run_traffic(3000, 1'b0, order);

    do_reset();
    run_traffic(60, 1'b1, order);
    n_vec++;
    if (order.len() < 10 || order.substr(0, 9) != "DDDDFDDDDF") begin
      n_err++;
      $display("FAIL streak order: got %s expected DDDDFDDDDF...", order);
    end

    z_rst = 1'b1;
    @(posedge clk); #1;
    z_rst = 1'b0; z_freq = 1'b1; z_faddr = 'h40; z_rreq = 1'b1; z_daddr = 'h80; z_rdy = 1'b1;
    @(posedge clk); #1;
    chk("z0 first mem_req", z_mreq, 1);
    chk("z0 first grant_fetch", z_gf, 1);
    chk("z0 first mem_addr", z_maddr, 'h40);
    @(posedge clk); #1;
    chk("z0 accept mem_req", z_mreq, 0);
    z_rv = 1'b1; z_rdata = 'h1234;
    @(posedge clk); #1;
    chk("z0 fetch_valid", z_fv, 1);
    chk("z0 data_valid idle", z_dv, 0);
    chk("z0 inst_read", z_inst, 'h1234);
    z_rv = 1'b0; z_freq = 1'b0;
    @(posedge clk); #1;
    chk("z0 resp mem_req", z_mreq, 0);
    @(posedge clk); #1;
    chk("z0 second mem_req", z_mreq, 1);
    chk("z0 second grant_fetch", z_gf, 0);
    chk("z0 second mem_addr", z_maddr, 'h80);
    chk("z0 second mem_we", z_mwe, 0);
    chk("z0 second mem_wmask", z_mwmask, 0);
    chk("z0 second mem_wdata", z_mwdata, 0);
    @(posedge clk); #1;
    z_rv = 1'b1; z_rdata = 'h5678;
    @(posedge clk); #1;
    chk("z0 data_valid", z_dv, 1);
    chk("z0 data_read", z_dread, 'h5678);
    z_rv = 1'b0; z_rreq = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
